// File: rtl/sm_pkg.sv
// Shared constants and FSM state encoding for the sign-magnitude divider.
package sm_pkg;

  localparam int W     = 21;
  localparam int MAG_W = W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module sm_div_step
  import sm_pkg::*;
#(
  parameter int MW = MAG_W
) (
  input  logic [MW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [MW-1:0] i_div,
  output logic [MW-1:0] o_rem,
  output logic          o_qbit
);

  // The shifted remainder can momentarily need one bit more than the magnitude,
  // so compare and subtract on MW+1 bits; the difference always fits back in MW.
  logic [MW:0] w_shift;
  logic [MW:0] w_div_ext;
  logic [MW:0] w_diff;

  assign w_shift   = {i_rem, i_bit};
  assign w_div_ext = {1'b0, i_div};
  assign w_diff    = w_shift - w_div_ext;

  // Select the subtracted or the kept remainder depending on the compare.
  always_comb begin
    o_qbit = 1'b0;
    o_rem  = w_shift[MW-1:0];
    if (w_shift >= w_div_ext) begin
      o_qbit = 1'b1;
      o_rem  = w_diff[MW-1:0];
    end
  end

endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude divider: one restoring step per cycle, MSB first.
module sm_divider #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         div_by_zero
);

  import sm_pkg::*;

  localparam int MW = W - 1;
  localparam int CW = $clog2(W);

  state_t        r_state;
  logic [MW-1:0] r_a;      // dividend bits not yet consumed, quotient bits shifted in below
  logic [MW-1:0] r_b;
  logic [MW-1:0] r_rem;
  logic [CW-1:0] r_count;
  logic          r_sign_q;
  logic          r_sign_r;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic          r_done;
  logic          r_dbz;

  logic [MW-1:0] w_rem_next;
  logic          w_qbit;
  logic [MW-1:0] w_qmag;
  logic          w_b_zero;
  logic          w_a_zero;

  sm_div_step #(.MW(MW)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_a[MW-1]),
    .i_div  (r_b),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  assign w_qmag   = {r_a[MW-2:0], w_qbit};
  assign w_b_zero = (B[MW-1:0] == '0);
  assign w_a_zero = (A[MW-1:0] == '0);

  assign ready       = (r_state == IDLE);
  assign done        = r_done;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;

  // Control FSM with registered results; done pulses in the cycle after DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_count  <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= A[MW-1:0];
            r_b      <= B[MW-1:0];
            r_rem    <= '0;
            r_count  <= CW'(MW);
            r_sign_q <= A[W-1] ^ B[W-1];
            r_sign_r <= A[W-1];
            if (w_b_zero) begin
              // Zero divisor short-circuits: saturated quotient, remainder = dividend.
              r_state <= DONE;
              r_dbz   <= 1'b1;
              r_q     <= {A[W-1] ^ B[W-1], {MW{1'b1}}};
              r_r     <= {A[W-1] & ~w_a_zero, A[MW-1:0]};
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_a     <= w_qmag;
          r_rem   <= w_rem_next;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= DONE;
            r_dbz   <= 1'b0;
            r_q     <= {r_sign_q & (w_qmag != '0), w_qmag};
            r_r     <= {r_sign_r & (w_rem_next != '0), w_rem_next};
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_divider.sv
// Directed testbench for sm_divider with hand-computed expected results.
module tb_sm_divider;

  localparam int W = 21;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  sm_divider #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .ready       (ready),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency to done, check results and that no extra done follows.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input int exp_lat, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input logic exp_dbz);
    int lat;
    int extra;
    lat   = 0;
    extra = 0;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = hold;
    A     = '1;
    B     = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_Q"}, Q, exp_q);
    check_eq({tag, "_R"}, R, exp_r);
    check_eq({tag, "_dbz"}, div_by_zero, exp_dbz);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq({tag, "_extra_done"}, extra, 0);
    $display("op %s A=%0h B=%0h lat=%0d Q=%0h R=%0h dbz=%0b", tag, a, b, lat, Q, R, div_by_zero);
  endtask

  localparam logic [W-1:0] NEG = 21'h100000;

  initial begin
    int dones;
    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_Q", Q, 0);
    check_eq("rst_R", R, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    rst = 1'b1;

    run_op("pp", 21'd100, 21'd7, 1'b0, 21, 21'd14, 21'd2, 1'b0);
    run_op("np", NEG | 21'd100, 21'd7, 1'b0, 21, NEG | 21'd14, NEG | 21'd2, 1'b0);
    run_op("pn", 21'd100, NEG | 21'd7, 1'b0, 21, NEG | 21'd14, 21'd2, 1'b0);
    run_op("zero_a", 21'd0, NEG | 21'd5, 1'b0, 21, 21'd0, 21'd0, 1'b0);
    run_op("div0", 21'd5, 21'd0, 1'b0, 1, 21'h0FFFFF, 21'd5, 1'b1);
    run_op("max_hold", 21'd1048575, 21'd1, 1'b1, 21, 21'd1048575, 21'd0, 1'b0);

    // Abort in the middle of RUN.
    dones = 0;
    @(negedge clk);
    A     = 21'd100;
    B     = 21'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("abort_busy", ready, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_ready", ready, 1);
    check_eq("abort_Q", Q, 0);
    check_eq("abort_R", R, 0);
    check_eq("abort_done", done, 0);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    $display("op abort ready=%0b Q=%0h R=%0h dones=%0d", ready, Q, R, dones);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_divider.md
SM_DIVIDER -- requirements
Module: sm_divider

Interface
REQ-001 Parameter W SHALL be default 21, the total sign-magnitude word width: bit W-1 is the sign (1 = negative) and bits W-2:0 are the magnitude.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, the synchronous active-low reset.
REQ-004 Port start SHALL be input, 1 bit, a request to divide; it is sampled only while ready=1.
REQ-005 Port A SHALL be input, W bits, the sign-magnitude dividend, sampled on the accepting edge.
REQ-006 Port B SHALL be input, W bits, the sign-magnitude divisor, sampled on the accepting edge.
REQ-007 Port ready SHALL be output, 1 bit, high exactly when the FSM is in IDLE.
REQ-008 Port done SHALL be output, 1 bit, a one-cycle pulse marking valid results.
REQ-009 Port Q SHALL be output, W bits, the sign-magnitude quotient.
REQ-010 Port R SHALL be output, W bits, the sign-magnitude remainder.
REQ-011 Port div_by_zero SHALL be output, 1 bit, high with done when the magnitude of B is 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL latch A and B, clear the partial remainder, load the step counter with W-1, and go to RUN (or to DONE if the magnitude of B is 0).
REQ-014 IDLE with start=0 SHALL remain in IDLE with Q, R and div_by_zero held.
REQ-015 RUN SHALL perform one restoring-division step per cycle, for exactly W-1 (20) cycles, MSB first:
- shift partial remainder left and bring in the next dividend bit;
- if partial remainder >= magnitude of B, subtract it and set the quotient bit to 1;
- otherwise keep the partial remainder and set the quotient bit to 0.
REQ-016 After the last step, RUN SHALL go to DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-017 Results SHALL follow these latency and validity rules:
- latency from the accepting edge to done high is W (21) cycles for a nonzero divisor and 1 cycle for a zero divisor;
- Q and R are updated only on entry to DONE and then held until the next DONE.
REQ-018 Sign rules SHALL be as follows:
- sign of Q = sign of A XOR sign of B;
- sign of R = sign of A;
- any zero-magnitude result has its sign forced to 0 (no negative zero).
REQ-019 Divide by zero SHALL set div_by_zero=1, Q magnitude all ones with sign per REQ-018, and R = A with sign per REQ-018.
REQ-020 start, A and B SHALL be ignored while ready=0; back-to-back requests are accepted earliest in the cycle after done.
REQ-021 Magnitude arithmetic SHALL be unsigned, W-1 bits wide, with one extra guard bit on the partial-remainder comparison; no overflow is possible.

Reset
REQ-022 With rst=0 at a rising edge, the FSM SHALL go to IDLE and Q, R, the internal registers, done and div_by_zero SHALL be cleared; ready then reads 1.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.

Structure
REQ-024 Package sm_pkg SHALL hold the constant W=21, the constant MAG_W=W-1, and the state enumeration {IDLE, RUN, DONE}.
REQ-025 A combinational sub-module sm_div_step SHALL implement one restoring step (shift-compare-subtract); sm_divider SHALL instantiate it once.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- A=+100, B=+7 -> done 21 cycles after accept; Q=+14, R=+2, div_by_zero=0.
- A=-100, B=+7 -> Q=-14, R=-2; and A=+100, B=-7 -> Q=-14, R=+2.
- A=+0, B=-5 -> Q=+0, R=+0 (sign bits 0).
- A=+5, B=+0 -> div_by_zero=1 and done 1 cycle after accept; Q=+0xFFFFF, R=+5.
- A=+1048575, B=+1 -> Q=+1048575, R=+0; start held high during RUN is ignored and exactly one done pulse occurs.
- rst=0 mid-RUN (cycle 10) -> next cycle ready=1, Q=0, R=0, and no done pulse.
